demux_router: RTL and testbench
===============================

Name: demux_router

Overview:
- 1-to-4 stream demultiplexer; the inverse of the 4:1 select muxes in this codebase.
- One input stream with a 2-bit destination select is steered to one of four output channels.
- Each output channel has its own single-entry holding register and a valid/ready handshake.
- A wrapping counter records the number of accepted transfers.

Parameters:
- WIDTH, 8, data width of input and of each output channel.
- CNT_W, 8, width of the accepted-transfer counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- in_data  input  WIDTH  payload.
- in_sel  input  2  destination channel index, {s1,s0} encoding: 00→ch0, 01→ch1, 10→ch2, 11→ch3.
- in_valid  input  1  source presents in_data/in_sel.
- in_ready  output  1  router can accept this cycle.
- out_data  output  4*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- out_valid  output  4  per-channel valid.
- out_ready  input  4  per-channel sink ready.
- xfer_count  output  CNT_W  number of accepted input transfers, modulo 2^CNT_W.

Behaviour:
- Reset (async assert, sync-safe deassert by system):
  - out_valid=4'b0000, out_data=0, xfer_count=0.
  - in_ready follows its combinational rule.
- Per-channel state: full[k] equals out_valid[k]. out_data[k] is held stable while out_valid[k]=1 and out_ready[k]=0.
- in_ready is combinational: in_ready = !out_valid[in_sel] || out_ready[in_sel].
  - in_ready depends on in_sel and out_ready only, never on in_valid.
- Accept: fires when in_valid && in_ready at a rising edge.
  - Captures in_data into channel in_sel.
  - Sets out_valid[in_sel]=1 on the next cycle (latency 1 cycle).
  - Increments xfer_count by 1, wrapping from 2^CNT_W-1 to 0.
- Drain: fires when out_valid[k] && out_ready[k] at an edge; clears out_valid[k] unless channel k is refilled in the same edge.
- Simultaneous drain and accept on the same channel:
  - New data loads and out_valid stays 1.
  - Sustains 1 transfer/cycle per channel.
- Simultaneous drain on channel j and accept on channel k≠j: both take effect independently.
- Channels other than in_sel are unaffected by an accept; multiple channels may drain in the same cycle.
- Stalls:
  - Destination full and not draining → in_ready=0, no capture, no count change.
  - Source must hold in_data/in_sel/in_valid until accepted.
- in_sel change while in_valid=1 and stalled is a protocol violation by the source; the router evaluates in_ready on the current in_sel with no error flag.
- in_valid=0: no state change except drains.
- Ordering: transfers to the same channel appear on that channel in acceptance order. No ordering is guaranteed across channels.
- Reset mid-operation: all held data is discarded immediately (out_valid→0 asynchronously) and xfer_count→0. Any transfer in flight at that edge is lost.
- out_data for an invalid channel retains its last value and is don't-care to sinks.

Test Plan:
- Reset:
  - Stimulus: assert rst with out_ready=4'b0000 and in_sel=2.
  - Required: out_valid=0000, xfer_count=0, in_ready=1. Assert rst asynchronously mid-cycle → outputs clear without waiting for a clk edge.
- Single route:
  - Stimulus: in_sel=2'b10, in_data=8'hA5, in_valid=1 for one cycle, out_ready=0000.
  - Required: next cycle out_valid=0100, out_data[23:16]=A5, xfer_count=1. Then out_ready[2]=1 → out_valid=0000 the following cycle.
- Backpressure isolation:
  - Stimulus: fill ch1 with 8'h11 while out_ready=0000. Then present in_sel=01, 8'h22.
  - Required: in_ready=0 and ch1 holds 11; count unchanged.
  - Stimulus: switch to in_sel=11, 8'h33.
  - Required: accepted, out_valid=1010.
  - Stimulus: raise out_ready[1] with 8'h22 re-presented.
  - Required: accepted the same cycle; ch1 shows 22 next.
- Full throughput:
  - Stimulus: out_ready=1111; stream 8'h00..8'h0F to ch0 back-to-back.
  - Required: in_ready=1 every cycle; ch0 outputs 00..0F on consecutive cycles; xfer_count=16.
- Parallel drain and fill:
  - Stimulus: ch0 and ch3 full; same edge drains ch0 and accepts into ch3 (out_ready=1001, in_sel=11, 8'h77).
  - Required: out_valid=1000, ch3 data=77.
- Counter wrap:
  - Stimulus: CNT_W=4; perform 17 accepted transfers across random channels with out_ready=1111.
  - Required: xfer_count=1, and no transfer is lost or duplicated per scoreboard.

Source files
------------

// File: rtl/demux_router.sv
// 1-to-4 stream demultiplexer: one valid/ready input steered by in_sel into
// four single-entry output channels, with a wrapping accepted-transfer counter.

module demux_router_chan #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] in_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    // A load on the draining edge wins, so a channel can sustain one beat per cycle.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = in_data;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
endmodule

module demux_router #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [1:0]         in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [4*WIDTH-1:0] out_data,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready,
    output logic [CNT_W-1:0]   xfer_count
);
    logic             accept;
    logic [3:0]       load;
    logic [CNT_W-1:0] count_q, count_d;

    // Readiness looks only at the addressed channel, never at in_valid.
    assign in_ready = !out_valid[in_sel] || out_ready[in_sel];
    assign accept   = in_valid && in_ready;

    always_comb begin
        load = 4'b0000;
        if (accept) load[in_sel] = 1'b1;
        count_d = count_q + {{(CNT_W-1){1'b0}}, accept};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign xfer_count = count_q;

    genvar k;
    generate
        for (k = 0; k < 4; k++) begin : g_chan
            demux_router_chan #(.WIDTH(WIDTH)) u_chan (
                .clk       (clk),
                .rst       (rst),
                .load      (load[k]),
                .in_data   (in_data),
                .out_ready (out_ready[k]),
                .out_valid (out_valid[k]),
                .out_data  (out_data[k*WIDTH +: WIDTH])
            );
        end
    endgenerate
endmodule

// File: tb/tb_demux_router.sv
// Directed bench for demux_router: one 8-bit-counter instance and one 4-bit-counter
// instance share all inputs so the wrap case runs alongside the main sequence.

module tb_demux_router;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic        in_valid;
    logic [3:0]  out_ready;
    logic        in_ready8, in_ready4;
    logic [31:0] out_data8, out_data4;
    logic [3:0]  out_valid8, out_valid4;
    logic [7:0]  cnt8;
    logic [3:0]  cnt4;

    int n_chk  = 0;
    int n_fail = 0;

    demux_router #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
        .in_ready(in_ready8), .out_data(out_data8), .out_valid(out_valid8),
        .out_ready(out_ready), .xfer_count(cnt8)
    );

    demux_router #(.WIDTH(8), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
        .in_ready(in_ready4), .out_data(out_data4), .out_valid(out_valid4),
        .out_ready(out_ready), .xfer_count(cnt4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] sel;
        logic [7:0] dat;

        // Reset with channel 2 addressed and nothing ready
        rst = 1'b1; in_data = 8'h00; in_sel = 2'd2; in_valid = 1'b0; out_ready = 4'b0000;
        #1;
        chk("rst_valid", {28'd0, out_valid8}, 32'h0);
        chk("rst_count", {24'd0, cnt8}, 32'h0);
        chk("rst_ready", {31'd0, in_ready8}, 32'h1);
        chk("rst_data", out_data8, 32'h0);
        step(); step();
        rst = 1'b0;

        // Single route to ch2
        in_sel = 2'd2; in_data = 8'hA5; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("route_valid", {28'd0, out_valid8}, 32'h4);
        chk("route_data", {24'd0, out_data8[23:16]}, 32'hA5);
        chk("route_count", {24'd0, cnt8}, 32'h1);
        out_ready = 4'b0100;
        step();
        out_ready = 4'b0000;
        chk("route_drain", {28'd0, out_valid8}, 32'h0);

        // Backpressure isolation on ch1
        in_sel = 2'd1; in_data = 8'h11; in_valid = 1'b1;
        step();
        in_data = 8'h22;
        #1;
        chk("bp_ready", {31'd0, in_ready8}, 32'h0);
        step();
        chk("bp_hold", {24'd0, out_data8[15:8]}, 32'h11);
        chk("bp_count", {24'd0, cnt8}, 32'h2);
        chk("bp_valid", {28'd0, out_valid8}, 32'h2);
        in_valid = 1'b0;
        #1;
        chk("bp_ready_novalid", {31'd0, in_ready8}, 32'h0);
        in_sel = 2'd3; in_data = 8'h33; in_valid = 1'b1;
        #1;
        chk("bp_other_ready", {31'd0, in_ready8}, 32'h1);
        step();
        chk("bp_other_valid", {28'd0, out_valid8}, 32'hA);
        chk("bp_other_count", {24'd0, cnt8}, 32'h3);
        in_sel = 2'd1; in_data = 8'h22; out_ready = 4'b0010;
        #1;
        chk("bp_release_ready", {31'd0, in_ready8}, 32'h1);
        step();
        in_valid = 1'b0; out_ready = 4'b0000;
        chk("bp_release_data", {24'd0, out_data8[15:8]}, 32'h22);
        chk("bp_release_valid", {28'd0, out_valid8}, 32'hA);
        chk("bp_release_count", {24'd0, cnt8}, 32'h4);

        // Drain ch1, fill ch0, then drain ch0 while refilling ch3
        out_ready = 4'b0010;
        step();
        out_ready = 4'b0000;
        in_sel = 2'd0; in_data = 8'h44; in_valid = 1'b1;
        step();
        chk("par_pre_valid", {28'd0, out_valid8}, 32'h9);
        out_ready = 4'b1001; in_sel = 2'd3; in_data = 8'h77;
        step();
        in_valid = 1'b0; out_ready = 4'b0000;
        chk("par_valid", {28'd0, out_valid8}, 32'h8);
        chk("par_data", {24'd0, out_data8[31:24]}, 32'h77);
        chk("par_count", {24'd0, cnt8}, 32'h6);

        // Asynchronous reset between edges
        #2;
        rst = 1'b1;
        #1;
        chk("async_valid", {28'd0, out_valid8}, 32'h0);
        chk("async_count", {24'd0, cnt8}, 32'h0);
        step();
        rst = 1'b0;

        // Full throughput into ch0
        out_ready = 4'b1111; in_sel = 2'd0; in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_data = 8'(i);
            #1;
            chk("thru_ready", {31'd0, in_ready8}, 32'h1);
            step();
            chk("thru_valid", {28'd0, out_valid8}, 32'h1);
            chk("thru_data", {24'd0, out_data8[7:0]}, i);
        end
        in_valid = 1'b0;
        chk("thru_count", {24'd0, cnt8}, 32'd16);
        step();
        chk("thru_empty", {28'd0, out_valid8}, 32'h0);

        // 17 random-channel transfers; 4-bit counter must wrap to 1
        rst = 1'b1;
        #1;
        rst = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            sel = 2'($urandom_range(3, 0));
            dat = 8'($urandom_range(255, 0));
            in_sel = sel; in_data = dat;
            step();
            chk("wrap_valid", {28'd0, out_valid4}, 32'(4'b0001 << sel));
            chk("wrap_data", {24'd0, out_data4[sel*8 +: 8]}, {24'd0, dat});
        end
        in_valid = 1'b0;
        chk("wrap_count4", {28'd0, cnt4}, 32'h1);
        chk("wrap_count8", {24'd0, cnt8}, 32'd17);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
